// File: rtl/ct_iu_div_iter_pkg.sv
// Shared definitions for the iterative integer divider.
//   - FSM state encoding
//   - datapath width
//   - bit offsets of the 258-bit result-cache record
//       {word, signed, rem[63:0], quot[63:0], divisor[63:0], dividend[63:0]}
package ct_iu_div_iter_pkg;

    localparam int DIV_XLEN      = 64;
    localparam int DIV_CNT_W     = 6;
    localparam int DIV_REC_W     = 258;

    localparam int REC_DIVIDEND_LSB = 0;
    localparam int REC_DIVISOR_LSB  = 64;
    localparam int REC_QUOT_LSB     = 128;
    localparam int REC_REM_LSB      = 192;
    localparam int REC_SIGNED_BIT   = 256;
    localparam int REC_WORD_BIT     = 257;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_ITER = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_e;

    // Sign-extend a 32-bit value to the full datapath width.
    function automatic logic [DIV_XLEN-1:0] sext_word(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/ct_iu_div_iter_neg.sv
// Conditional two's-complement negate, 64 bits.
//   neg_en : 1 = output -src, 0 = output src
//   src    : input value
//   rslt   : result
module ct_iu_div_iter_neg
    import ct_iu_div_iter_pkg::*;
(
    input  logic                neg_en,
    input  logic [DIV_XLEN-1:0] src,
    output logic [DIV_XLEN-1:0] rslt
);

    assign rslt = neg_en ? (~src + {{(DIV_XLEN-1){1'b0}}, 1'b1}) : src;

endmodule

// File: rtl/ct_iu_div_iter.sv
// Iterative restoring radix-2 integer divider (div/divu/divw/divuw style).
// Ports:
//   forever_cpuclk        clock (rising edge)
//   cpurst                asynchronous active-high reset
//   div_req_vld           request valid
//   div_req_signed        1 = signed operands
//   div_req_word          1 = 32-bit operation on src[31:0]
//   div_req_src0/src1     dividend / divisor
//   div_flush             abort in-flight divide
//   div_req_rdy           high in IDLE
//   div_rslt_vld          one-cycle result pulse
//   div_rslt_quot/rem     quotient / remainder (hold between results)
//   div_entry_write_en    result-cache write strobe (with div_rslt_vld)
//   div_entry_write_data  258-bit result-cache record
module ct_iu_div_iter
    import ct_iu_div_iter_pkg::*;
(
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    input  logic                 div_req_vld,
    input  logic                 div_req_signed,
    input  logic                 div_req_word,
    input  logic [DIV_XLEN-1:0]  div_req_src0,
    input  logic [DIV_XLEN-1:0]  div_req_src1,
    input  logic                 div_flush,
    output logic                 div_req_rdy,
    output logic                 div_rslt_vld,
    output logic [DIV_XLEN-1:0]  div_rslt_quot,
    output logic [DIV_XLEN-1:0]  div_rslt_rem,
    output logic                 div_entry_write_en,
    output logic [DIV_REC_W-1:0] div_entry_write_data
);

    div_state_e            div_state;
    logic [DIV_CNT_W-1:0]  iter_cnt;
    logic [DIV_XLEN-1:0]   dividend_q;
    logic [DIV_XLEN-1:0]   divisor_q;
    logic                  word_q;
    logic                  signed_q;
    logic                  quot_sign;
    logic                  rem_sign;
    logic [DIV_XLEN-1:0]   divisor_mag;
    logic [DIV_XLEN-1:0]   quot_shift;   // dividend bits shift out the top, quotient bits in at the bottom
    logic [DIV_XLEN-1:0]   part_rem;
    logic [DIV_REC_W-1:0]  rslt_rec;

    logic                  req_acc;
    logic [DIV_XLEN-1:0]   src0_ext;
    logic [DIV_XLEN-1:0]   src1_ext;
    logic                  dividend_sign;
    logic                  divisor_sign;
    logic                  neg_a_en;
    logic                  neg_b_en;
    logic [DIV_XLEN-1:0]   neg_a_src;
    logic [DIV_XLEN-1:0]   neg_b_src;
    logic [DIV_XLEN-1:0]   neg_a_rslt;
    logic [DIV_XLEN-1:0]   neg_b_rslt;
    logic [DIV_XLEN:0]     trial;
    logic [DIV_XLEN:0]     trial_diff;
    logic                  trial_ge;
    logic [DIV_XLEN-1:0]   fix_quot;
    logic [DIV_XLEN-1:0]   fix_rem;

    function automatic logic [DIV_XLEN-1:0] ext_operand(
        input logic [DIV_XLEN-1:0] x,
        input logic                sgn,
        input logic                word
    );
        if (!word)
            return x;
        else if (sgn)
            return sext_word(x[31:0]);
        else
            return {32'b0, x[31:0]};
    endfunction

    assign req_acc  = div_req_vld && (div_state == DIV_IDLE) && !div_flush;
    assign src0_ext = ext_operand(div_req_src0, div_req_signed, div_req_word);
    assign src1_ext = ext_operand(div_req_src1, div_req_signed, div_req_word);

    assign dividend_sign = signed_q & dividend_q[DIV_XLEN-1];
    assign divisor_sign  = signed_q & divisor_q[DIV_XLEN-1];

    // The two negators take operand magnitudes in PREP and restore result
    // signs in FIX; the select follows the current state.
    assign neg_a_src = (div_state == DIV_FIX) ? quot_shift : dividend_q;
    assign neg_a_en  = (div_state == DIV_FIX) ? quot_sign  : dividend_sign;
    assign neg_b_src = (div_state == DIV_FIX) ? part_rem   : divisor_q;
    assign neg_b_en  = (div_state == DIV_FIX) ? rem_sign   : divisor_sign;

    ct_iu_div_iter_neg u_neg_a (
        .neg_en (neg_a_en),
        .src    (neg_a_src),
        .rslt   (neg_a_rslt)
    );

    ct_iu_div_iter_neg u_neg_b (
        .neg_en (neg_b_en),
        .src    (neg_b_src),
        .rslt   (neg_b_rslt)
    );

    // 65-bit trial subtract. part_rem < divisor_mag always holds, so the
    // difference lands in [0, 2^64) when trial >= divisor and in
    // [2^64, 2^65) otherwise: bit 64 alone is the compare result.
    assign trial      = {part_rem, quot_shift[DIV_XLEN-1]};
    assign trial_diff = trial - {1'b0, divisor_mag};
    assign trial_ge   = ~trial_diff[DIV_XLEN];

    assign fix_quot = word_q ? sext_word(neg_a_rslt[31:0]) : neg_a_rslt;
    assign fix_rem  = word_q ? sext_word(neg_b_rslt[31:0]) : neg_b_rslt;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            div_state   <= DIV_IDLE;
            iter_cnt    <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            word_q      <= 1'b0;
            signed_q    <= 1'b0;
            quot_sign   <= 1'b0;
            rem_sign    <= 1'b0;
            divisor_mag <= '0;
            quot_shift  <= '0;
            part_rem    <= '0;
            rslt_rec    <= '0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (req_acc) begin
                        dividend_q <= src0_ext;
                        divisor_q  <= src1_ext;
                        word_q     <= div_req_word;
                        signed_q   <= div_req_signed;
                        div_state  <= DIV_PREP;
                    end
                end
                DIV_PREP: begin
                    if (div_flush) begin
                        div_state <= DIV_IDLE;
                    end else begin
                        quot_sign   <= dividend_sign ^ divisor_sign;
                        rem_sign    <= dividend_sign;
                        divisor_mag <= neg_b_rslt;
                        // Word ops align the 32-bit magnitude to the top so the
                        // same MSB-first loop works with 32 iterations.
                        quot_shift  <= word_q ? {neg_a_rslt[31:0], 32'b0} : neg_a_rslt;
                        part_rem    <= '0;
                        iter_cnt    <= word_q ? DIV_CNT_W'(31) : DIV_CNT_W'(63);
                        if (divisor_q == '0) begin
                            rslt_rec  <= {word_q, signed_q, dividend_q, {DIV_XLEN{1'b1}},
                                          divisor_q, dividend_q};
                            div_state <= DIV_DONE;
                        end else begin
                            div_state <= DIV_ITER;
                        end
                    end
                end
                DIV_ITER: begin
                    if (div_flush) begin
                        div_state <= DIV_IDLE;
                    end else begin
                        part_rem   <= trial_ge ? trial_diff[DIV_XLEN-1:0] : trial[DIV_XLEN-1:0];
                        quot_shift <= {quot_shift[DIV_XLEN-2:0], trial_ge};
                        if (iter_cnt == '0)
                            div_state <= DIV_FIX;
                        else
                            iter_cnt <= iter_cnt - 1'b1;
                    end
                end
                DIV_FIX: begin
                    if (div_flush) begin
                        div_state <= DIV_IDLE;
                    end else begin
                        rslt_rec  <= {word_q, signed_q, fix_rem, fix_quot, divisor_q, dividend_q};
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    div_state <= DIV_IDLE;
                end
                default: begin
                    div_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign div_req_rdy          = (div_state == DIV_IDLE);
    // A flush landing on DONE must still squash the pulses.
    assign div_rslt_vld         = (div_state == DIV_DONE) && !div_flush;
    assign div_entry_write_en   = (div_state == DIV_DONE) && !div_flush;
    assign div_rslt_quot        = rslt_rec[REC_QUOT_LSB +: DIV_XLEN];
    assign div_rslt_rem         = rslt_rec[REC_REM_LSB +: DIV_XLEN];
    assign div_entry_write_data = rslt_rec;

endmodule

// File: doc/ct_iu_div_iter.md
CT_IU_DIV_ITER -- requirements
Module: ct_iu_div_iter

Interface
REQ-001 SHALL have port forever_cpuclk  in  1  sole clock; all flops sample on its rising edge.
REQ-002 SHALL have port cpurst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port div_req_vld  in  1  divide request valid.
REQ-004 SHALL have port div_req_signed  in  1  1 = signed operands.
REQ-005 SHALL have port div_req_word  in  1  1 = 32-bit op; operands taken from [31:0] and sign/zero-extended per div_req_signed.
REQ-006 SHALL have port div_req_src0  in  64  dividend.
REQ-007 SHALL have port div_req_src1  in  64  divisor.
REQ-008 SHALL have port div_flush  in  1  abort the in-flight divide.
REQ-009 SHALL have port div_req_rdy  out  1  high only in IDLE.
REQ-010 SHALL have port div_rslt_vld  out  1  one-cycle result pulse.
REQ-011 SHALL have port div_rslt_quot  out  64  quotient.
REQ-012 SHALL have port div_rslt_rem  out  64  remainder.
REQ-013 SHALL have port div_entry_write_en  out  1  result-cache write strobe.
REQ-014 SHALL have port div_entry_write_data  out  258  cache record {word, signed, rem[63:0], quot[63:0], divisor[63:0], dividend[63:0]}, bit 257 down to 0.

Function
REQ-015 SHALL implement FSM IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
REQ-016 SHALL accept a request when div_req_vld && div_req_rdy && !div_flush; accepted operands, after extension, are latched for the record.
REQ-017 In PREP, SHALL form unsigned magnitudes and record quotient and remainder signs; remainder sign = dividend sign; quotient sign = XOR of operand signs (signed ops only).
REQ-018 If the divisor is zero, PREP SHALL go directly to DONE with quot = all-ones and rem = extended dividend.
REQ-019 ITER SHALL run a restoring radix-2 loop, one quotient bit per cycle, for N = 64 cycles (N = 32 when word), using a 65-bit partial-remainder compare.
REQ-020 A 6/7-bit iteration counter SHALL load N-1 on PREP exit and leave ITER when it reaches 0.
REQ-021 FIX SHALL two's-complement-negate the magnitudes per the recorded signs; word results SHALL be sign-extended from bit 31 (divuw included).
REQ-022 Signed overflow SHALL give quot = most-negative value and rem = 0 (64-bit: 0x8000_0000_0000_0000); no special path is required beyond the magnitude arithmetic.
REQ-023 In DONE, div_rslt_vld and div_entry_write_en SHALL both pulse for exactly one cycle, with outputs valid in that cycle.
REQ-024 Latency from acceptance cycle to div_rslt_vld SHALL be N+3 cycles, or 2 cycles for divide-by-zero.
REQ-025 div_flush in any non-IDLE state SHALL return to IDLE on the next edge with no rslt_vld and no write; a flush coinciding with DONE SHALL suppress both pulses.
REQ-026 A new request SHALL be acceptable in the cycle after DONE.
REQ-027 div_rslt_quot, div_rslt_rem and div_entry_write_data SHALL hold their last values outside DONE.

Reset
REQ-028 On cpurst, FSM = IDLE, counter = 0, all datapath registers = 0.
REQ-029 On cpurst, div_rslt_vld = 0, div_entry_write_en = 0, div_req_rdy = 1 on the first cycle after deassertion.
REQ-030 Reset asserted mid-divide SHALL abort it with no output pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, DIV_XLEN = 64, and the 258-bit record field offsets.
REQ-032 One sub-module, ct_iu_div_iter_neg (64-bit conditional negate), SHALL be instantiated for PREP and FIX.

Verification
REQ-033 Unsigned 100 / 7, 64-bit -> quot 14, rem 2, rslt_vld exactly 67 cycles after accept, write_data[257:256] = 2'b00.
REQ-034 Signed -7 / 2 -> quot 0xFFFF_FFFF_FFFF_FFFD, rem 0xFFFF_FFFF_FFFF_FFFF.
REQ-035 5 / 0 -> quot all-ones, rem 5, rslt_vld 2 cycles after accept.
REQ-036 Signed 0x8000_0000_0000_0000 / -1 -> quot 0x8000_0000_0000_0000, rem 0.
REQ-037 Word signed 0xFFFF_FFFF / 2 -> quot 0, rem 0xFFFF_FFFF_FFFF_FFFF, latency 35.
REQ-038 Flush in ITER cycle 10 -> no rslt_vld or write, div_req_rdy high next cycle; back-to-back request accepted in that cycle completes correctly.
